plb_wr_arbiter: RTL and testbench

Shares the single PLB master write port (IP2Bus_MstWr_* / Bus2IP_Mst_*) between NUM_REQ write requesters: the pixel framebuffer writer, the framebuffer clear engine, and future masters. It sits between the requesters and the PLB master IPIF. It grants one single-beat write at a time using round-robin priority, registers address and data for the duration of the transaction, and routes the acknowledge and complete signals back to the granted requester only.

---
 rtl/plb_arb_pkg.sv | 25 ++
 rtl/plb_wr_arbiter_if.sv | 44 ++++
 rtl/rr_pick.sv | 45 ++++
 rtl/plb_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_plb_wr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plb_arb_pkg
//  Description : Shared definitions for the PLB write-port arbiter: the
//                arbiter state encoding and the default parameter values
//                used by the interface, the picker and the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package plb_arb_pkg;

    // Arbiter state encoding, two bits wide.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_CMPLT = 2'd2
    } arb_state_t;

    // Default widths and limits.
    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 1023;

endpackage : plb_arb_pkg
`default_nettype wire

// File: rtl/plb_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : plb_wr_arbiter_if
//  Description : PLB master-IPIF single-beat write port. The arbiter side
//                uses the master modport, the IPIF (or a bus model) uses
//                the slave modport.
//  Signals     : IP2Bus_MstWr_Req   - write request          (master -> slave)
//                IP2Bus_Mst_Addr    - write address          (master -> slave)
//                IP2Bus_MstWr_d     - write data             (master -> slave)
//                Bus2IP_Mst_CmdAck  - command acknowledge    (slave -> master)
//                Bus2IP_Mst_Cmplt   - transaction complete   (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface plb_wr_arbiter_if
    import plb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              IP2Bus_MstWr_Req;
    logic [ADDR_W-1:0] IP2Bus_Mst_Addr;
    logic [DATA_W-1:0] IP2Bus_MstWr_d;
    logic              Bus2IP_Mst_CmdAck;
    logic              Bus2IP_Mst_Cmplt;

    modport master (
        output IP2Bus_MstWr_Req,
        output IP2Bus_Mst_Addr,
        output IP2Bus_MstWr_d,
        input  Bus2IP_Mst_CmdAck,
        input  Bus2IP_Mst_Cmplt
    );

    modport slave (
        input  IP2Bus_MstWr_Req,
        input  IP2Bus_Mst_Addr,
        input  IP2Bus_MstWr_d,
        output Bus2IP_Mst_CmdAck,
        output Bus2IP_Mst_Cmplt
    );

endinterface : plb_wr_arbiter_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first
//                asserted request at or after ptr, wrapping modulo NUM_REQ.
//  Ports       : req   - request vector
//                ptr   - round-robin start position (0..NUM_REQ-1)
//                valid - at least one request is asserted
//                idx   - index of the selected request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import plb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Scan from the farthest offset to the nearest so that the last
        // hit written, i.e. the one closest to ptr, is the winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/plb_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : plb_wr_arbiter
//  Description : Shares one PLB master write port between NUM_REQ write
//                requesters. One single-beat write is in flight at a time,
//                chosen round-robin; address and data are registered for
//                the whole transaction and the bus acknowledge/complete
//                are steered back to the granted requester only.
//  Ports       : PLB_clk      - clock
//                reset_n      - asynchronous active-low reset
//                req_wr_req   - per-requester write request
//                req_addr     - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//                req_data     - packed write data, same packing
//                req_cmdack   - one-hot command acknowledge
//                req_cmplt    - one-hot completion pulse
//                req_timeout  - one-hot watchdog abort (timeout build only)
//                bus          - PLB master write port (master modport)
//                busy         - arbiter not in IDLE
//                grant_idx    - current or last granted requester
//  Config      : PLB_WR_ARB_TIMEOUT_EN - enables the TIMEOUT_CYC watchdog
//                and the req_timeout port.
//  Revision    : 1.0 - initial release
// ============================================================================
module plb_wr_arbiter
    import plb_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       PLB_clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_cmdack,
    output logic [NUM_REQ-1:0]         req_cmplt,
`ifdef PLB_WR_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]         req_timeout,
`endif
    plb_wr_arbiter_if.master           bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t        state_q,     state_d;
    logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] data_q,      data_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic [NUM_REQ-1:0] grant_onehot;
    logic              cmdack_fire;
    logic              done_fire;
    logic              timeout_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_wr_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Bus responses only count while a transaction is in the matching state.
    assign cmdack_fire  = (state_q == ISSUE) && bus.Bus2IP_Mst_CmdAck;
    assign done_fire    = (cmdack_fire && bus.Bus2IP_Mst_Cmplt) ||
                          ((state_q == WAIT_CMPLT) && bus.Bus2IP_Mst_Cmplt);
    assign next_ptr     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
    assign grant_onehot = NUM_REQ'(1) << grant_idx_q;

`ifdef PLB_WR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;

    // Held at zero in IDLE, so every ISSUE entry starts from zero. The
    // count never passes TIMEOUT_CYC because the limit always leaves
    // the busy states (via timeout or a same-cycle completion).
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // A completion in the limit cycle takes precedence over the abort.
    assign timeout_fire = (state_q != IDLE) && (wdog_q == CNT_W'(TIMEOUT_CYC)) && !done_fire;
    assign req_timeout  = timeout_fire ? grant_onehot : '0;
`else
    logic unused_timeout_cfg;

    assign timeout_fire       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

    // Next-state and datapath latch logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_d = pick_idx;
                    addr_d      = req_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                    data_d      = req_data[int'(pick_idx) * DATA_W +: DATA_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (done_fire || timeout_fire) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (cmdack_fire) begin
                    state_d  = WAIT_CMPLT;
                end
            end
            WAIT_CMPLT: begin
                if (done_fire || timeout_fire) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PLB_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign bus.IP2Bus_MstWr_Req = (state_q == ISSUE);
    assign bus.IP2Bus_Mst_Addr  = addr_q;
    assign bus.IP2Bus_MstWr_d   = data_q;

    assign req_cmdack = cmdack_fire ? grant_onehot : '0;
    assign req_cmplt  = done_fire   ? grant_onehot : '0;
    assign busy       = (state_q != IDLE);
    assign grant_idx  = grant_idx_q;

endmodule : plb_wr_arbiter
`default_nettype wire

// File: tb/tb_plb_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plb_wr_arbiter
//  Description : Directed self-checking bench for plb_wr_arbiter with three
//                requesters. The timeout scenario is built only when
//                PLB_WR_ARB_TIMEOUT_EN is defined (TIMEOUT_CYC = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plb_wr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            PLB_clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_wr_req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_cmdack;
    logic [N-1:0]    req_cmplt;
    logic            busy;
    logic [1:0]      grant_idx;
`ifdef PLB_WR_ARB_TIMEOUT_EN
    logic [N-1:0]    req_timeout;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    plb_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    plb_wr_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .PLB_clk     (PLB_clk),
        .reset_n     (reset_n),
        .req_wr_req  (req_wr_req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_cmdack  (req_cmdack),
        .req_cmplt   (req_cmplt),
`ifdef PLB_WR_ARB_TIMEOUT_EN
        .req_timeout (req_timeout),
`endif
        .bus         (bus_if),
        .busy        (busy),
        .grant_idx   (grant_idx)
    );

    always #5 PLB_clk = ~PLB_clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic slot();
        @(posedge PLB_clk);
        #1;
    endtask

    task automatic set_bus(input logic ack, input logic cmp);
        bus_if.Bus2IP_Mst_CmdAck = ack;
        bus_if.Bus2IP_Mst_Cmplt  = cmp;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        slot();
        slot();
        reset_n = 1'b1;
    endtask

    task automatic load_table();
        req_addr = {32'hA000_0300, 32'hA000_0200, 32'hA000_0100};
        req_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001};
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_wr_req = '0;
        load_table();
        set_bus(1'b1, 1'b1);
        slot(); slot(); slot();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus_if.IP2Bus_MstWr_Req); end
        n_cmp++; if (bus_if.IP2Bus_Mst_Addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus_if.IP2Bus_Mst_Addr); end
        n_cmp++; if (bus_if.IP2Bus_MstWr_d !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus_if.IP2Bus_MstWr_d); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (req_cmdack !== 3'b000) begin n_fail++; $display("FAIL reset_cmdack: got %b want 000", req_cmdack); end
        n_cmp++; if (req_cmplt !== 3'b000) begin n_fail++; $display("FAIL reset_cmplt: got %b want 000", req_cmplt); end
        set_bus(1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        // Stray bus responses in IDLE must be ignored.
        slot();
        set_bus(1'b1, 1'b1);
        #1;
        n_cmp++; if (req_cmdack !== 3'b000 || req_cmplt !== 3'b000) begin n_fail++; $display("FAIL idle_ignore: got ack %b cmplt %b want 000 000", req_cmdack, req_cmplt); end
        slot();
        set_bus(1'b0, 1'b0);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_busy: got %b want 0", busy); end

        req_addr[63:32] = 32'h1000_0040;
        req_data[63:32] = 32'hDEAD_BEEF;
        req_wr_req      = 3'b010;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b want 0", busy); end
        slot(); #1;
        n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== 1'b1) begin n_fail++; $display("FAIL single_req_latency: got %b want 1", bus_if.IP2Bus_MstWr_Req); end
        n_cmp++; if (bus_if.IP2Bus_Mst_Addr !== 32'h1000_0040) begin n_fail++; $display("FAIL single_addr: got %h want 10000040", bus_if.IP2Bus_Mst_Addr); end
        n_cmp++; if (bus_if.IP2Bus_MstWr_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", bus_if.IP2Bus_MstWr_d); end
        n_cmp++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", grant_idx); end
        n_cmp++; if (req_cmdack !== 3'b000) begin n_fail++; $display("FAIL single_early_ack: got %b want 000", req_cmdack); end
        slot(); #1;
        n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== 1'b1) begin n_fail++; $display("FAIL single_req_hold: got %b want 1", bus_if.IP2Bus_MstWr_Req); end
        slot();
        set_bus(1'b1, 1'b0);
        #1;
        n_cmp++; if (req_cmdack !== 3'b010) begin n_fail++; $display("FAIL single_cmdack: got %b want 010", req_cmdack); end
        n_cmp++; if (req_cmplt !== 3'b000) begin n_fail++; $display("FAIL single_no_cmplt: got %b want 000", req_cmplt); end
        slot();
        req_wr_req = 3'b000;
        #1;   // CmdAck still high: must be ignored in WAIT_CMPLT
        n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait: got req %b busy %b want 0 1", bus_if.IP2Bus_MstWr_Req, busy); end
        n_cmp++; if (req_cmdack !== 3'b000) begin n_fail++; $display("FAIL single_wait_ack: got %b want 000", req_cmdack); end
        slot();
        set_bus(1'b0, 1'b1);
        #1;
        n_cmp++; if (req_cmplt !== 3'b010) begin n_fail++; $display("FAIL single_cmplt: got %b want 010", req_cmplt); end
        n_cmp++; if (bus_if.IP2Bus_Mst_Addr !== 32'h1000_0040) begin n_fail++; $display("FAIL single_addr_held: got %h want 10000040", bus_if.IP2Bus_Mst_Addr); end
        slot();
        set_bus(1'b0, 1'b0);
        #1;
        n_cmp++; if (busy !== 1'b0 || req_cmplt !== 3'b000) begin n_fail++; $display("FAIL single_done: got busy %b cmplt %b want 0 000", busy, req_cmplt); end
        n_cmp++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL single_last_grant: got %0d want 1", grant_idx); end
        load_table();
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        req_wr_req = 3'b011;
        slot();
        set_bus(1'b1, 1'b1);
        #1;
        n_cmp++; if (grant_idx !== 2'd0 || bus_if.IP2Bus_MstWr_Req !== 1'b1) begin n_fail++; $display("FAIL simul_first: got grant %0d req %b want 0 1", grant_idx, bus_if.IP2Bus_MstWr_Req); end
        n_cmp++; if (bus_if.IP2Bus_Mst_Addr !== 32'hA000_0100) begin n_fail++; $display("FAIL simul_addr0: got %h want a0000100", bus_if.IP2Bus_Mst_Addr); end
        n_cmp++; if (req_cmdack !== 3'b001 || req_cmplt !== 3'b001) begin n_fail++; $display("FAIL simul_ack0: got ack %b cmplt %b want 001 001", req_cmdack, req_cmplt); end
        slot();
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b010;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_gap: got busy %b want 0", busy); end
        slot();
        set_bus(1'b1, 1'b1);
        #1;
        n_cmp++; if (grant_idx !== 2'd1 || bus_if.IP2Bus_MstWr_d !== 32'hD000_0002) begin n_fail++; $display("FAIL simul_second: got grant %0d data %h want 1 d0000002", grant_idx, bus_if.IP2Bus_MstWr_d); end
        n_cmp++; if (req_cmdack !== 3'b010 || req_cmplt !== 3'b010) begin n_fail++; $display("FAIL simul_ack1: got ack %b cmplt %b want 010 010", req_cmdack, req_cmplt); end
        slot();
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b000;
        slot();
    endtask

    task automatic test_contention();
        int exp_g [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        logic [2:0] oh;
        pulse_reset();
        req_wr_req = 3'b111;
        for (int t = 0; t < 9; t++) begin
            int w;
            w = 0;
            slot();
            while (bus_if.IP2Bus_MstWr_Req !== 1'b1 && w < 8) begin
                slot();
                w++;
            end
            n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== 1'b1) begin n_fail++; $display("FAIL cont_wait_req t%0d: got %b want 1", t, bus_if.IP2Bus_MstWr_Req); end
            oh = 3'b001 << exp_g[t];
            n_cmp++; if (grant_idx !== 2'(exp_g[t])) begin n_fail++; $display("FAIL cont_grant t%0d: got %0d want %0d", t, grant_idx, exp_g[t]); end
            n_cmp++; if (bus_if.IP2Bus_Mst_Addr !== 32'hA000_0000 + 32'h100 * (exp_g[t] + 1)) begin n_fail++; $display("FAIL cont_addr t%0d: got %h", t, bus_if.IP2Bus_Mst_Addr); end
            set_bus(1'b1, 1'b0);
            #1;
            n_cmp++; if (req_cmdack !== oh) begin n_fail++; $display("FAIL cont_ack t%0d: got %b want %b", t, req_cmdack, oh); end
            slot();
            set_bus(1'b0, 1'b1);
            #1;
            n_cmp++; if (req_cmplt !== oh) begin n_fail++; $display("FAIL cont_cmplt t%0d: got %b want %b", t, req_cmplt, oh); end
            slot();
            set_bus(1'b0, 1'b0);
        end
        req_wr_req = 3'b000;
        slot();
    endtask

    task automatic test_back_to_back();
        logic exp_req [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   exp_g   [7] = '{0, 0, 0, 1, 1, 0, 0};
        pulse_reset();
        req_wr_req = 3'b011;
        set_bus(1'b1, 1'b1);   // bus ties CmdAck and Cmplt high
        #1;
        for (int s = 0; s < 7; s++) begin
            if (s > 0) begin
                slot(); #1;
            end
            n_cmp++; if (bus_if.IP2Bus_MstWr_Req !== exp_req[s]) begin n_fail++; $display("FAIL b2b_req s%0d: got %b want %b", s, bus_if.IP2Bus_MstWr_Req, exp_req[s]); end
            if (exp_req[s]) begin
                n_cmp++; if (grant_idx !== 2'(exp_g[s]) || req_cmplt !== (3'b001 << exp_g[s])) begin n_fail++; $display("FAIL b2b_grant s%0d: got grant %0d cmplt %b want %0d", s, grant_idx, req_cmplt, exp_g[s]); end
            end else begin
                n_cmp++; if (busy !== 1'b0 || req_cmdack !== 3'b000) begin n_fail++; $display("FAIL b2b_idle s%0d: got busy %b ack %b want 0 000", s, busy, req_cmdack); end
            end
        end
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b000;
        slot();
    endtask

    task automatic test_reset_mid();
        req_wr_req = 3'b100;
        slot();
        set_bus(1'b1, 1'b0);
        #1;
        n_cmp++; if (req_cmdack !== 3'b100) begin n_fail++; $display("FAIL rmid_ack2: got %b want 100", req_cmdack); end
        slot();
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b000;
        #1;
        n_cmp++; if (busy !== 1'b1 || bus_if.IP2Bus_MstWr_Req !== 1'b0) begin n_fail++; $display("FAIL rmid_wait: got busy %b req %b want 1 0", busy, bus_if.IP2Bus_MstWr_Req); end
        reset_n = 1'b0;
        set_bus(1'b0, 1'b1);
        #1;
        n_cmp++; if (busy !== 1'b0 || bus_if.IP2Bus_MstWr_Req !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got busy %b req %b want 0 0", busy, bus_if.IP2Bus_MstWr_Req); end
        n_cmp++; if (req_cmplt !== 3'b000) begin n_fail++; $display("FAIL rmid_no_cmplt: got %b want 000", req_cmplt); end
        n_cmp++; if (grant_idx !== 2'd0 || bus_if.IP2Bus_Mst_Addr !== 32'h0) begin n_fail++; $display("FAIL rmid_regs: got grant %0d addr %h want 0 0", grant_idx, bus_if.IP2Bus_Mst_Addr); end
        slot();
        reset_n = 1'b1;
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b101;
        slot();
        set_bus(1'b1, 1'b1);
        #1;
        n_cmp++; if (grant_idx !== 2'd0 || req_cmdack !== 3'b001) begin n_fail++; $display("FAIL rmid_first_grant: got grant %0d ack %b want 0 001", grant_idx, req_cmdack); end
        slot();
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b000;
        slot();
    endtask

`ifdef PLB_WR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        req_wr_req = 3'b011;
        for (int k = 0; k <= 16; k++) begin
            slot(); #1;
            if (k < 16) begin
                n_cmp++; if (req_timeout !== 3'b000 || bus_if.IP2Bus_MstWr_Req !== 1'b1) begin n_fail++; $display("FAIL tmo_early k%0d: got tmo %b req %b want 000 1", k, req_timeout, bus_if.IP2Bus_MstWr_Req); end
            end else begin
                n_cmp++; if (req_timeout !== 3'b001) begin n_fail++; $display("FAIL tmo_pulse: got %b want 001", req_timeout); end
            end
        end
        slot();
        req_wr_req = 3'b010;
        #1;
        n_cmp++; if (busy !== 1'b0 || bus_if.IP2Bus_MstWr_Req !== 1'b0 || req_timeout !== 3'b000) begin n_fail++; $display("FAIL tmo_idle: got busy %b req %b tmo %b want 0 0 000", busy, bus_if.IP2Bus_MstWr_Req, req_timeout); end
        slot();
        set_bus(1'b1, 1'b1);
        #1;
        n_cmp++; if (grant_idx !== 2'd1 || req_cmdack !== 3'b010) begin n_fail++; $display("FAIL tmo_next: got grant %0d ack %b want 1 010", grant_idx, req_cmdack); end
        slot();
        set_bus(1'b0, 1'b0);
        req_wr_req = 3'b000;
        slot();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n    = 1'b0;
        req_wr_req = '0;
        set_bus(1'b0, 1'b0);
        load_table();
        test_reset();
        test_single();
        test_simultaneous();
        test_contention();
        test_back_to_back();
        test_reset_mid();
`ifdef PLB_WR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_plb_wr_arbiter
`default_nettype wire
